mips_multicycle_control: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath.
- Sits directly upstream of the ALU control decoder and drives its 2-bit Aluop input (11 = add, 01 = sub, 00 = R-type, decoded from Func).
- Sequences fetch, decode, execute, memory and writeback. Stalls on a memory ready handshake.
- Counts retired instructions.

---
 rtl/mips_multicycle_control.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// mips_multicycle_control
//
// Main control FSM for a multi-cycle MIPS datapath. It steps through fetch,
// decode, execute, memory and writeback, and holds in any memory state until
// MemReady is seen. It drives the 2-bit Aluop code for the downstream ALU
// control decoder (11 = add, 01 = sub, 00 = R-type via Func) and counts
// retired instructions.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (state -> FETCH, count -> 0,
//                every strobe forced low while asserted)
//   Opcode[5:0]  instruction bits [31:26] from the instruction register
//   MemReady     memory access completes in the current cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, AluSrcA, AluSrcB[1:0], Aluop[1:0], PCSource[1:0]
//                datapath controls (Moore decode of the state register;
//                IRWrite/PCWrite in FETCH are qualified by MemReady)
//   State[3:0]   current state, for debug
//   InstrCount   retired-instruction counter, CNT_W bits, wraps
//   Illegal      only with MC_CTRL_ILLEGAL_TRAP_EN: high in the HALT state
//
// Configuration macro:
//   MC_CTRL_ILLEGAL_TRAP_EN  unknown opcodes trap into HALT (left only by
//                            reset). Without it they retire as a NOP.
// ---------------------------------------------------------------------------
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [1:0]       Aluop,
    output logic [1:0]       PCSource,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             Illegal
`endif
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    // Registered control word; 'fetch' marks FETCH so that IRWrite/PCWrite
    // can be qualified by MemReady outside the flops.
    typedef struct packed {
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        logic       illegal;
`endif
    } ctrl_t;

    // Moore decode of one state into the full control word.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c        = '0;
        c.alu_op = 2'b11;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b00;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_ADDIWB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT: begin
                c.illegal = 1'b1;
            end
`endif
            default: begin
                c.alu_op = 2'b11;
            end
        endcase
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             retire_s;

    // Next-state logic; memory states hold until MemReady.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (MemReady) state_d = S_DECODE;
                else          state_d = S_FETCH;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_SW) state_d = S_MEMWR;
                else                 state_d = S_MEMRD;
            end
            S_MEMRD: begin
                if (MemReady) state_d = S_MEMWB;
                else          state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (MemReady) state_d = S_FETCH;
                else          state_d = S_MEMWR;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_HALT:   state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Retirement: any completing state moving into FETCH. DECODE only gets
    // here with an unknown opcode in the non-trapping build (NOP retire).
    always_comb begin
        retire_s = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH,
                S_ADDIWB, S_JUMP, S_DECODE: retire_s = 1'b1;
                default:                    retire_s = 1'b0;
            endcase
        end else begin
            retire_s = 1'b0;
        end
    end

    // Counter next value and the control word of the next state.
    always_comb begin
        if (retire_s) cnt_d = cnt_q + CNT_W'(1);
        else          cnt_d = cnt_q;
        ctrl_d = decode(state_d);
    end

    // State, counter and registered control word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ctrl_q  <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Strobes are gated by rst_n so that none can fire while reset is held,
    // even though the control flops already show the FETCH decode.
    assign PCWrite     = rst_n & (ctrl_q.pc_write | (ctrl_q.fetch & MemReady));
    assign IRWrite     = rst_n & ctrl_q.fetch & MemReady;
    assign PCWriteCond = rst_n & ctrl_q.pc_write_cond;
    assign MemRead     = rst_n & ctrl_q.mem_read;
    assign MemWrite    = rst_n & ctrl_q.mem_write;
    assign RegWrite    = rst_n & ctrl_q.reg_write;
    assign IorD        = ctrl_q.iord;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign RegDst      = ctrl_q.reg_dst;
    assign AluSrcA     = ctrl_q.alu_src_a;
    assign AluSrcB     = ctrl_q.alu_src_b;
    assign Aluop       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign State       = state_q;
    assign InstrCount  = cnt_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign Illegal     = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_mips_multicycle_control.sv
// ---------------------------------------------------------------------------
// Bench for mips_multicycle_control (built with CNT_W = 4 so the counter
// wraps quickly). A driver issues whole instructions; for each cycle it
// pushes the expected state, control word and count into a scoreboard
// queue, and a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       Opcode;
    logic             MemReady;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, AluSrcA;
    logic [1:0]       AluSrcB, Aluop, PCSource;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;
    logic             illegal_s;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } ctrl_t;

    typedef struct {
        int    st;
        ctrl_t c;
        int    cnt;
        bit    ill;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .Aluop(Aluop),
        .PCSource(PCSource), .State(State), .InstrCount(InstrCount)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , .Illegal(illegal_s)
`endif
    );
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal_s = 1'b0;
`endif

    // Control values each state is documented to present.
    function automatic ctrl_t exp_ctrl(input int st, input bit mr);
        ctrl_t c;
        c = '0;
        c.aluop = 2'b11;
        case (st)
            0:  begin c.mrd = 1'b1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            1:  c.srcb = 2'b11;
            2:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            3:  begin c.iord = 1'b1; c.mrd = 1'b1; end
            4:  begin c.rw = 1'b1; c.m2r = 1'b1; end
            5:  begin c.iord = 1'b1; c.mwr = 1'b1; end
            6:  begin c.srca = 1'b1; c.aluop = 2'b00; end
            7:  begin c.rw = 1'b1; c.rdst = 1'b1; end
            8:  begin c.srca = 1'b1; c.aluop = 2'b01; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            9:  begin c.srca = 1'b1; c.srcb = 2'b10; end
            10: c.rw = 1'b1;
            11: begin c.pcw = 1'b1; c.pcsrc = 2'b10; end
            default: c.aluop = 2'b11;
        endcase
        return c;
    endfunction

    function automatic ctrl_t act_ctrl();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, Aluop, PCSource};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected values while rst_n is held low.
    function automatic ctrl_t reset_ctrl();
        ctrl_t c;
        c = exp_ctrl(0, 1'b0);
        c.mrd = 1'b0;
        return c;
    endfunction

    // One clock cycle: drive inputs, record expectation, advance.
    task automatic cyc(input int st, input bit mr, input logic [5:0] op);
        exp_t e;
        MemReady = mr;
        Opcode   = op;
        e.st  = st;
        e.c   = exp_ctrl(st, mr);
        e.cnt = exp_cnt;
        e.ill = (st == 12);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic int rand_wait();
        if ($urandom_range(0, 2) == 0) return int'($urandom_range(1, 3));
        else return 0;
    endfunction

    // Whole instruction from the architectural state path of its opcode.
    // forced_wait < 0 picks random memory waits.
    task automatic run_instr(input logic [5:0] op, input int forced_wait);
        int seq[$];
        int n;
        case (op)
            OP_LW:   seq = '{0, 1, 2, 3, 4};
            OP_SW:   seq = '{0, 1, 2, 5};
            OP_R:    seq = '{0, 1, 6, 7};
            OP_ADDI: seq = '{0, 1, 9, 10};
            OP_BEQ:  seq = '{0, 1, 8};
            OP_J:    seq = '{0, 1, 11};
            default: seq = '{0, 1};
        endcase
        foreach (seq[i]) begin
            if (seq[i] == 0 || seq[i] == 3 || seq[i] == 5) begin
                if (forced_wait < 0) n = rand_wait();
                else if (seq[i] == 0) n = 0;
                else n = forced_wait;
                repeat (n) cyc(seq[i], 1'b0, op);
                cyc(seq[i], 1'b1, op);
            end else begin
                cyc(seq[i], 1'($urandom_range(0, 1)), op);
            end
        end
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    // Monitor: compare each cycle's outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state", 32'(State), e.st);
                chk("ctrl", 32'(act_ctrl()), 32'(e.c));
                chk("count", 32'(InstrCount), e.cnt);
                chk("illegal", 32'(illegal_s), 32'(e.ill));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[$];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        ops.push_back(OP_BAD);
`endif
        rst_n = 1'b0;
        MemReady = 1'b1;
        Opcode = OP_R;
        #12;
        chk("rst_state", 32'(State), 0);
        chk("rst_count", 32'(InstrCount), 0);
        chk("rst_ctrl", 32'(act_ctrl()), 32'(reset_ctrl()));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed: lw, R, beq, sw with 3 waits, j.
        run_instr(OP_LW, 0);
        run_instr(OP_R, 0);
        run_instr(OP_BEQ, 0);
        run_instr(OP_SW, 3);
        run_instr(OP_J, 0);

        // Random mix, enough to wrap the 4-bit counter a few times.
        for (int k = 0; k < 50; k++)
            run_instr(ops[$urandom_range(0, ops.size() - 1)], -1);

        // Asynchronous reset in the middle of EXEC.
        cyc(0, 1'b1, OP_R);
        cyc(1, 1'b1, OP_R);
        chk("pre_rst_exec", 32'(State), 6);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", 32'(State), 0);
        chk("midrst_count", 32'(InstrCount), 0);
        chk("midrst_ctrl", 32'(act_ctrl()), 32'(reset_ctrl()));
        @(posedge clk);
        #1;
        chk("rst_hold_state", 32'(State), 0);
        rst_n = 1'b1;
        exp_cnt = 0;
        run_instr(OP_ADDI, -1);
        run_instr(OP_LW, -1);

        // Unknown opcode.
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        cyc(0, 1'b1, OP_BAD);
        cyc(1, 1'b1, OP_BAD);
        repeat (10) cyc(12, 1'($urandom_range(0, 1)), OP_BAD);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_state", 32'(State), 0);
        chk("halt_rst_illegal", 32'(illegal_s), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
`else
        run_instr(OP_BAD, 0);
`endif
        run_instr(OP_ADDI, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
